vga_pattern_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_pattern_gen_if.sv | 13 +
 rtl/vga_pos_tracker.sv | 85 ++++++++
 rtl/vga_pattern_gen.sv | 127 ++++++++++++
 tb/tb_vga_pattern_gen.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared types and RGB565 colour constants for the VGA pattern pipeline.
package vga_pkg;

   typedef enum logic [1:0] {
      PAT_BARS     = 2'd0,
      PAT_CHECKER  = 2'd1,
      PAT_GRADIENT = 2'd2,
      PAT_SOLID    = 2'd3
   } pattern_e;

   localparam logic [15:0] C_WHITE   = 16'hFFFF;
   localparam logic [15:0] C_YELLOW  = 16'hFFE0;
   localparam logic [15:0] C_CYAN    = 16'h07FF;
   localparam logic [15:0] C_GREEN   = 16'h07E0;
   localparam logic [15:0] C_MAGENTA = 16'hF81F;
   localparam logic [15:0] C_RED     = 16'hF800;
   localparam logic [15:0] C_BLUE    = 16'h001F;
   localparam logic [15:0] C_BLACK   = 16'h0000;

   // Colour-bar palette, left to right.
   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      logic [15:0] c;
      unique case (idx)
         3'd0: c = C_WHITE;
         3'd1: c = C_YELLOW;
         3'd2: c = C_CYAN;
         3'd3: c = C_GREEN;
         3'd4: c = C_MAGENTA;
         3'd5: c = C_RED;
         3'd6: c = C_BLUE;
         3'd7: c = C_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Upstream timing stream from the VGA timing controller plus the requested pattern.
interface vga_pattern_gen_if;
   import vga_pkg::*;

   logic     hsync;
   logic     vsync;
   logic     active;
   pattern_e mode;

   modport master (output hsync, output vsync, output active, output mode);
   modport slave  (input hsync, input vsync, input active, input mode);

endinterface

// File: rtl/vga_pos_tracker.sv
// Stage 0: follows the incoming timing stream to produce pixel position, frame count,
// the per-frame pattern latch and the frame-start strobe.
module vga_pos_tracker
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_ACTIVE  = 480,
   parameter bit          VSYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   vga_pattern_gen_if.slave src_i,
   output logic [10:0]      x_o,
   output logic [9:0]       y_o,
   output logic [7:0]       frame_o,
   output pattern_e         mode_o,
   output logic             synced_o,
   output logic             frame_start_o
);

   localparam logic [10:0] XMax = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  YMax = 10'(V_ACTIVE - 1);

   logic        active_d_q;
   logic        vsync_d_q;
   logic [10:0] x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic [7:0]  frame_q, frame_d;
   pattern_e    mode_q, mode_d;
   logic        synced_q, synced_d;
   logic        vs_edge;
   logic        line_end;

   always_comb begin
      vs_edge  = (src_i.vsync == VSYNC_POL) && (vsync_d_q != VSYNC_POL);
      line_end = active_d_q & ~src_i.active;

      x_d = '0;
      if (src_i.active) begin
         x_d = (x_q == XMax) ? x_q : x_q + 11'd1;
      end

      y_d      = y_q;
      frame_d  = frame_q;
      mode_d   = mode_q;
      synced_d = synced_q;
      // A vsync edge overrides a coincident line end so the new frame starts on row 0.
      if (vs_edge) begin
         y_d      = '0;
         frame_d  = frame_q + 8'd1;
         mode_d   = src_i.mode;
         synced_d = 1'b1;
      end else if (line_end && (y_q != YMax)) begin
         y_d = y_q + 10'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_d_q <= 1'b0;
         vsync_d_q  <= ~VSYNC_POL;
         x_q        <= '0;
         y_q        <= '0;
         frame_q    <= '0;
         mode_q     <= PAT_BARS;
         synced_q   <= 1'b0;
      end else begin
         active_d_q <= src_i.active;
         vsync_d_q  <= src_i.vsync;
         x_q        <= x_d;
         y_q        <= y_d;
         frame_q    <= frame_d;
         mode_q     <= mode_d;
         synced_q   <= synced_d;
      end
   end

   assign x_o           = x_q;
   assign y_o           = y_q;
   assign frame_o       = frame_q;
   assign mode_o        = mode_q;
   assign synced_o      = synced_q;
   assign frame_start_o = vs_edge;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern stage behind the VGA timing controller: every output, including the
// re-timed syncs, lags the inputs that produced it by exactly two clocks.
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter bit          HSYNC_POL  = 1'b0,
   parameter bit          VSYNC_POL  = 1'b0,
   parameter int unsigned BAR_WIDTH  = 80,
   parameter int unsigned CHECK_LOG2 = 5
) (
   input  logic             clk,
   input  logic             rst,
   vga_pattern_gen_if.slave src_i,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             active_o,
   output logic [15:0]      rgb_o,
   output logic [10:0]      x_o,
   output logic [9:0]       y_o,
   output logic [7:0]       frame_o,
   output logic             frame_start_o
);

   logic [10:0] trk_x;
   logic [9:0]  trk_y;
   logic [7:0]  trk_frame;
   pattern_e    trk_mode;
   logic        trk_synced;
   logic        trk_fs;

   vga_pos_tracker #(
      .H_ACTIVE  (H_ACTIVE),
      .V_ACTIVE  (V_ACTIVE),
      .VSYNC_POL (VSYNC_POL)
   ) u_pos_tracker (
      .clk           (clk),
      .rst           (rst),
      .src_i         (src_i),
      .x_o           (trk_x),
      .y_o           (trk_y),
      .frame_o       (trk_frame),
      .mode_o        (trk_mode),
      .synced_o      (trk_synced),
      .frame_start_o (trk_fs)
   );

   logic        s1_hs_q, s1_vs_q, s1_act_q, s1_fs_q;
   logic [10:0] s1_x_q;
   logic [9:0]  s1_y_q;

   logic        hs_q, vs_q, act_q, fs_q;
   logic [15:0] rgb_q, rgb_d;
   logic [10:0] x_q;
   logic [9:0]  y_q;
   logic [7:0]  frame_q;
   logic [2:0]  bar;

   // Bar index by threshold compares; anything past the seventh edge stays in bar 7.
   always_comb begin
      bar = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (32'(s1_x_q) >= (32'(i) + 32'd1) * BAR_WIDTH) begin
            bar = 3'(i + 1);
         end
      end
   end

   always_comb begin
      rgb_d = C_BLACK;
      unique case (trk_mode)
         PAT_BARS:     rgb_d = bar_colour(bar);
         PAT_CHECKER:  rgb_d = (s1_x_q[CHECK_LOG2] ^ s1_y_q[CHECK_LOG2]) ? C_WHITE : C_BLACK;
         PAT_GRADIENT: rgb_d = {s1_x_q[9:5], s1_y_q[8:3], trk_frame[7:3]};
         PAT_SOLID:    rgb_d = C_BLUE;
      endcase
      if (!s1_act_q || !trk_synced) begin
         rgb_d = C_BLACK;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_hs_q  <= ~HSYNC_POL;
         s1_vs_q  <= ~VSYNC_POL;
         s1_act_q <= 1'b0;
         s1_fs_q  <= 1'b0;
         s1_x_q   <= '0;
         s1_y_q   <= '0;
         hs_q     <= ~HSYNC_POL;
         vs_q     <= ~VSYNC_POL;
         act_q    <= 1'b0;
         fs_q     <= 1'b0;
         rgb_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         frame_q  <= '0;
      end else begin
         s1_hs_q  <= src_i.hsync;
         s1_vs_q  <= src_i.vsync;
         s1_act_q <= src_i.active;
         s1_fs_q  <= trk_fs;
         s1_x_q   <= trk_x;
         s1_y_q   <= trk_y;
         hs_q     <= s1_hs_q;
         vs_q     <= s1_vs_q;
         act_q    <= s1_act_q;
         fs_q     <= s1_fs_q;
         rgb_q    <= rgb_d;
         x_q      <= s1_x_q;
         y_q      <= s1_y_q;
         // Sampled alongside rgb so the gradient blue field always equals frame_o[7:3].
         frame_q  <= trk_frame;
      end
   end

   assign hsync_o       = hs_q;
   assign vsync_o       = vs_q;
   assign active_o      = act_q;
   assign rgb_o         = rgb_q;
   assign x_o           = x_q;
   assign y_o           = y_q;
   assign frame_o       = frame_q;
   assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: a frame-level reference model checked every cycle,
// plus hand-computed pixel values at chosen coordinates.
module tb_vga_pattern_gen;
   import vga_pkg::*;

   localparam bit VSP = 1'b0;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        act;
      logic [15:0] rgb;
      logic [10:0] x;
      logic [9:0]  y;
      logic [7:0]  frame;
      logic        fs;
      pattern_e    mode;
      logic        synced;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hsync_o, vsync_o, active_o, frame_start_o;
   logic [15:0] rgb_o;
   logic [10:0] x_o;
   logic [9:0]  y_o;
   logic [7:0]  frame_o;

   int checks = 0;
   int errors = 0;
   int edges_driven = 0;
   int fs_seen = 0;
   bit wrap_seen = 1'b0;
   logic [7:0] prev_frame = 8'd0;
   logic [8:0] lit_mask = '0;

   // Reference model state: counts of things seen on the input stream.
   int       m_run, m_lines, m_frames;
   pattern_e m_mode;
   bit       m_synced;
   logic     m_prev_act, m_prev_vs;
   exp_t     cur, nxt;

   vga_pattern_gen_if src_if ();

   vga_pattern_gen #(
      .H_ACTIVE   (640),
      .V_ACTIVE   (480),
      .HSYNC_POL  (1'b0),
      .VSYNC_POL  (1'b0),
      .BAR_WIDTH  (80),
      .CHECK_LOG2 (5)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .src_i         (src_if),
      .hsync_o       (hsync_o),
      .vsync_o       (vsync_o),
      .active_o      (active_o),
      .rgb_o         (rgb_o),
      .x_o           (x_o),
      .y_o           (y_o),
      .frame_o       (frame_o),
      .frame_start_o (frame_start_o)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] bar_ref(input int b);
      case (b)
         0: return 16'hFFFF;
         1: return 16'hFFE0;
         2: return 16'h07FF;
         3: return 16'h07E0;
         4: return 16'hF81F;
         5: return 16'hF800;
         6: return 16'h001F;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] ref_pixel(input pattern_e m, input int x, input int y,
                                             input int f);
      int b;
      case (m)
         PAT_BARS: begin
            b = x / 80;
            return bar_ref(b > 7 ? 7 : b);
         end
         PAT_CHECKER:  return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
         PAT_GRADIENT: return 16'((((x >> 5) & 31) << 11) | (((y >> 3) & 63) << 5) |
                                  ((f >> 3) & 31));
         default:      return 16'h001F;
      endcase
   endfunction

   function automatic exp_t rst_exp();
      exp_t e;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.mode = PAT_BARS;
      return e;
   endfunction

   task automatic model_reset();
      m_run = 0;
      m_lines = 0;
      m_frames = 0;
      m_mode = PAT_BARS;
      m_synced = 1'b0;
      m_prev_act = 1'b0;
      m_prev_vs = ~VSP;
   endtask

   // Outputs owed two clocks after the inputs now on the bus are sampled.
   task automatic model_step(output exp_t e);
      bit vs_edge, fall;
      vs_edge = (src_if.vsync == VSP) && (m_prev_vs != VSP);
      fall = m_prev_act && !src_if.active;
      e.hs = src_if.hsync;
      e.vs = src_if.vsync;
      e.act = src_if.active;
      e.x = 11'(m_run > 639 ? 639 : m_run);
      e.y = 10'(m_lines > 479 ? 479 : m_lines);
      e.fs = vs_edge;
      if (vs_edge) begin
         m_frames++;
         m_mode = src_if.mode;
         m_synced = 1'b1;
         m_lines = 0;
      end else if (fall) begin
         m_lines++;
      end
      e.frame = 8'(m_frames % 256);
      e.mode = m_mode;
      e.synced = m_synced;
      e.rgb = (e.act && m_synced) ? ref_pixel(m_mode, int'(e.x), int'(e.y), m_frames % 256)
                                  : 16'h0000;
      m_run = src_if.active ? m_run + 1 : 0;
      m_prev_act = src_if.active;
      m_prev_vs = src_if.vsync;
   endtask

   task automatic check_out(input exp_t e, input string name);
      checks++;
      if (hsync_o !== e.hs || vsync_o !== e.vs || active_o !== e.act || rgb_o !== e.rgb ||
          x_o !== e.x || y_o !== e.y || frame_o !== e.frame || frame_start_o !== e.fs) begin
         errors++;
         $display("FAIL %s t=%0t got hs=%b vs=%b act=%b rgb=%h x=%0d y=%0d fr=%0d fs=%b %s",
                  name, $time, hsync_o, vsync_o, active_o, rgb_o, x_o, y_o, frame_o,
                  frame_start_o, $sformatf("want hs=%b vs=%b act=%b rgb=%h x=%0d y=%0d fr=%0d fs=%b",
                  e.hs, e.vs, e.act, e.rgb, e.x, e.y, e.frame, e.fs));
      end
   endtask

   task automatic lit(input logic [15:0] want, input string name, input int bitn);
      checks++;
      if (bitn >= 0) lit_mask[bitn] = 1'b1;
      if (rgb_o !== want) begin
         errors++;
         $display("FAIL %s t=%0t x=%0d y=%0d rgb got %h want %h", name, $time, x_o, y_o,
                  rgb_o, want);
      end
   endtask

   task automatic check_literals(input exp_t e);
      if (!e.act) lit(16'h0000, "blank_black", -1);
      else if (!e.synced) lit(16'h0000, "unsynced_black", -1);
      else begin
         if (e.mode == PAT_BARS && e.x == 0) lit(16'hFFFF, "bars_x0", 0);
         if (e.mode == PAT_BARS && e.x == 80) lit(16'hFFE0, "bars_x80", 1);
         if (e.mode == PAT_BARS && e.x == 639) lit(16'h0000, "bars_x639", 2);
         if (e.mode == PAT_BARS && e.x == 480) lit(16'h001F, "bars_x480", 3);
         if (e.mode == PAT_CHECKER && e.x == 0 && e.y == 0) lit(16'h0000, "chk_0_0", 4);
         if (e.mode == PAT_CHECKER && e.x == 32 && e.y == 0) lit(16'hFFFF, "chk_32_0", 5);
         if (e.mode == PAT_CHECKER && e.x == 32 && e.y == 32) lit(16'h0000, "chk_32_32", 6);
         if (e.mode == PAT_SOLID && e.x == 0) lit(16'h001F, "solid", 7);
         if (e.mode == PAT_GRADIENT && e.frame == 8'd255 && e.x == 32 && e.y == 0)
            lit(16'h081F, "grad_f255", 8);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         model_reset();
         cur = rst_exp();
         nxt = rst_exp();
         check_out(cur, "reset_state");
      end else begin
         check_out(cur, "model");
         check_literals(cur);
         checks++;
         if (x_o > 11'd639 || y_o > 10'd479) begin
            errors++;
            $display("FAIL bounds t=%0t x=%0d y=%0d limit 639/479", $time, x_o, y_o);
         end
         if (frame_start_o === 1'b1) fs_seen++;
         if (prev_frame == 8'd255 && frame_o == 8'd0) wrap_seen = 1'b1;
         prev_frame = frame_o;
         cur = nxt;
         model_step(nxt);
      end
   end

   task automatic tick(input logic hs, input logic vs, input logic act);
      src_if.hsync = hs;
      src_if.vsync = vs;
      src_if.active = act;
      @(posedge clk);
      #1;
   endtask

   task automatic line(input int w);
      repeat (w) tick(1'b1, 1'b1, 1'b1);
      repeat (2) tick(1'b1, 1'b1, 1'b0);
      repeat (2) tick(1'b0, 1'b1, 1'b0);
      repeat (2) tick(1'b1, 1'b1, 1'b0);
   endtask

   task automatic vsync_pulse();
      edges_driven++;
      repeat (3) tick(1'b1, 1'b0, 1'b0);
      repeat (2) tick(1'b1, 1'b1, 1'b0);
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      #1;
      checks++;
      if (hsync_o !== 1'b1 || vsync_o !== 1'b1 || active_o !== 1'b0 || rgb_o !== 16'h0 ||
          x_o !== 11'd0 || y_o !== 10'd0 || frame_o !== 8'd0 || frame_start_o !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got hs=%b vs=%b act=%b rgb=%h x=%0d y=%0d fr=%0d fs=%b want 1 1 0 0000 0 0 0 0",
                  hsync_o, vsync_o, active_o, rgb_o, x_o, y_o, frame_o, frame_start_o);
      end
      repeat (3) tick(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      src_if.hsync = 1'b1;
      src_if.vsync = 1'b1;
      src_if.active = 1'b0;
      src_if.mode = PAT_BARS;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) tick(1'b1, 1'b1, 1'b0);

      vsync_pulse();
      repeat (2) line(640);

      src_if.mode = PAT_CHECKER;
      vsync_pulse();
      repeat (34) line(40);

      src_if.mode = PAT_BARS;
      vsync_pulse();
      for (int l = 0; l < 105; l++) begin
         if (l == 100) src_if.mode = PAT_SOLID;
         line(8);
      end
      vsync_pulse();
      repeat (3) line(8);

      src_if.mode = PAT_BARS;
      vsync_pulse();
      line(700);
      line(640);

      vsync_pulse();
      repeat (485) line(4);

      vsync_pulse();
      for (int l = 0; l < 210; l++) begin
         if (l == 200) reset_pulse();
         line(4);
      end
      vsync_pulse();
      repeat (3) line(8);

      src_if.mode = PAT_GRADIENT;
      repeat (256) begin
         vsync_pulse();
         line(40);
      end
      repeat (6) tick(1'b1, 1'b1, 1'b0);

      checks++;
      if (fs_seen != edges_driven) begin
         errors++;
         $display("FAIL frame_start_count got %0d want %0d", fs_seen, edges_driven);
      end
      checks++;
      if (!wrap_seen) begin
         errors++;
         $display("FAIL frame_wrap got no 255->0 transition want one");
      end
      checks++;
      if (lit_mask != 9'h1FF) begin
         errors++;
         $display("FAIL literal_coverage got %b want 111111111", lit_mask);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
